// File: rtl/riscv_pkg.sv
// Shared store-path encodings and the queued store entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Replicates store data across the word lanes and builds byte enables from size/offset.
// Latency: purely combinational.
// Backpressure: none; flags misaligned accesses so the caller can drop them.
module store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    // Lane replication lets memory pick the right bytes purely from be.
    always_comb begin
        wdata      = '0;
        be         = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_SB: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << offset;
            end
            F3_SH: begin
                wdata      = {2{data[15:0]}};
                be         = offset[1] ? 4'b1100 : 4'b0011;
                misaligned = offset[0];
            end
            F3_SW: begin
                wdata      = data;
                be         = 4'b1111;
                misaligned = |offset;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue between the memory stage and data memory, with load-hazard detection.
// Latency: a store accepted at edge N is offered on mem_req from cycle N+1.
// Backpressure: stalls stores when full and loads that hit a queued word; never a function of mem_ready.
module store_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        store_valid_from_memory,
    input  logic        load_valid_from_memory,
    input  logic [2:0]  funct3_from_memory,
    input  logic [31:0] addr_from_memory,
    input  logic [31:0] data_from_memory,
    output logic        stall_from_sb,
    output logic        misaligned_from_sb,
    output logic        empty_from_sb,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [31:0]   al_wdata;
    logic [3:0]    al_be;
    logic          al_mis;

    sb_entry_t     entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          misaligned_q;

    logic          full;
    logic          st_ok;
    logic          push;
    logic          pop;
    logic          hit;
    logic [PW-1:0] rel;
    sb_entry_t     head;

    store_align u_align (
        .funct3     (funct3_from_memory),
        .offset     (addr_from_memory[1:0]),
        .data       (data_from_memory),
        .wdata      (al_wdata),
        .be         (al_be),
        .misaligned (al_mis)
    );

    assign full  = (count == FULL_CNT);
    assign st_ok = store_valid_from_memory & ~al_mis;
    assign push  = st_ok & ~full;
    assign pop   = mem_req & mem_ready;

    // Entry storage needs no reset: slots are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{waddr: addr_from_memory[31:2], data: al_wdata, be: al_be};
        end
    end

    // Pointers and occupancy; reset discards every entry including one mid-handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // One-cycle pulse reporting that the store offered last cycle was dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misaligned_q <= 1'b0;
        else      misaligned_q <= store_valid_from_memory & al_mis;
    end

    // A slot is live when its distance from the head is below the count; the head itself counts.
    always_comb begin
        hit = 1'b0;
        rel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PW'(i) - rd_ptr;
            if (({1'b0, rel} < count) && (entries[i].waddr == addr_from_memory[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign stall_from_sb      = (st_ok & full) | (load_valid_from_memory & hit);
    assign misaligned_from_sb = misaligned_q;
    assign empty_from_sb      = (count == '0);
    assign mem_req            = ~empty_from_sb;

    // Head fields are forced to zero when idle so stale slots never leak onto the bus.
    assign head      = entries[rd_ptr];
    assign mem_addr  = mem_req ? {head.waddr, 2'b00} : '0;
    assign mem_wdata = mem_req ? head.data : '0;
    assign mem_be    = mem_req ? head.be : '0;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        store_valid_from_memory;
    logic        load_valid_from_memory;
    logic [2:0]  funct3_from_memory;
    logic [31:0] addr_from_memory;
    logic [31:0] data_from_memory;
    logic        stall_from_sb;
    logic        misaligned_from_sb;
    logic        empty_from_sb;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;

    int n_cmp;
    int n_fail;

    store_buffer #(.DEPTH(2)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .store_valid_from_memory (store_valid_from_memory),
        .load_valid_from_memory  (load_valid_from_memory),
        .funct3_from_memory      (funct3_from_memory),
        .addr_from_memory        (addr_from_memory),
        .data_from_memory        (data_from_memory),
        .stall_from_sb           (stall_from_sb),
        .misaligned_from_sb      (misaligned_from_sb),
        .empty_from_sb           (empty_from_sb),
        .mem_req                 (mem_req),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_be                  (mem_be),
        .mem_ready               (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mis;
        logic [31:0] wdata;
        logic [3:0]  be;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        store_valid_from_memory = 1'b1;
        funct3_from_memory      = f3;
        addr_from_memory        = a;
        data_from_memory        = d;
    endtask

    task automatic idle();
        store_valid_from_memory = 1'b0;
        load_valid_from_memory  = 1'b0;
        funct3_from_memory      = 3'b000;
        addr_from_memory        = 32'h0;
        data_from_memory        = 32'h0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'hABAB_ABAB, 4'b1000};
        vecs[1] = '{3'b000, 32'h0000_1000, 32'h1234_56CD, 1'b0, 32'hCDCD_CDCD, 4'b0001};
        vecs[2] = '{3'b000, 32'h0000_1002, 32'h0000_007F, 1'b0, 32'h7F7F_7F7F, 4'b0100};
        vecs[3] = '{3'b001, 32'h0000_2002, 32'h0000_1234, 1'b0, 32'h1234_1234, 4'b1100};
        vecs[4] = '{3'b001, 32'h0000_2000, 32'hFFFF_5678, 1'b0, 32'h5678_5678, 4'b0011};
        vecs[5] = '{3'b001, 32'h0000_2001, 32'h0000_1234, 1'b1, 32'h0,         4'b0000};
        vecs[6] = '{3'b010, 32'h0000_2001, 32'h1111_2222, 1'b1, 32'h0,         4'b0000};
        vecs[7] = '{3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b1111};
        vecs[8] = '{3'b011, 32'h0000_4000, 32'h5555_AAAA, 1'b1, 32'h0,         4'b0000};
        vecs[9] = '{3'b010, 32'h0000_4002, 32'h0BAD_F00D, 1'b1, 32'h0,         4'b0000};

        // Reset state
        rst = 1'b0;
        mem_ready = 1'b0;
        idle();
        #2;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_misaligned", 32'(misaligned_from_sb), 32'h0);
        check("rst_empty", 32'(empty_from_sb), 32'h1);
        check("rst_stall", 32'(stall_from_sb), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Alignment table: one store into an empty queue, observe head, then drain
        for (int i = 0; i < NV; i++) begin
            put_store(vecs[i].f3, vecs[i].addr, vecs[i].data);
            mem_ready = 1'b0;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(stall_from_sb), 32'h0);
            tick();
            idle();
            check($sformatf("vec%0d_misaligned", i), 32'(misaligned_from_sb), 32'(vecs[i].mis));
            check($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'(!vecs[i].mis));
            if (!vecs[i].mis) begin
                check($sformatf("vec%0d_addr", i), mem_addr, {vecs[i].addr[31:2], 2'b00});
                check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdata);
                check($sformatf("vec%0d_be", i), 32'(mem_be), 32'(vecs[i].be));
            end
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            check($sformatf("vec%0d_empty_after", i), 32'(empty_from_sb), 32'h1);
            check($sformatf("vec%0d_mis_pulse_end", i), 32'(misaligned_from_sb), 32'h0);
        end

        // Full queue: third store stalls, head stable, release after first pop, order kept
        mem_ready = 1'b0;
        put_store(3'b010, 32'h0000_5000, 32'hD0D0_D0D0);
        tick();
        put_store(3'b010, 32'h0000_5004, 32'hD1D1_D1D1);
        tick();
        put_store(3'b010, 32'h0000_5008, 32'hD2D2_D2D2);
        #1;
        check("full_stall", 32'(stall_from_sb), 32'h1);
        tick();
        check("full_stall_hold", 32'(stall_from_sb), 32'h1);
        check("full_head_addr", mem_addr, 32'h0000_5000);
        check("full_head_wdata", mem_wdata, 32'hD0D0_D0D0);
        check("full_head_be", 32'(mem_be), 32'hF);
        mem_ready = 1'b1;
        #1;
        check("full_stall_indep_ready", 32'(stall_from_sb), 32'h1);
        tick();
        check("after_pop_stall", 32'(stall_from_sb), 32'h0);
        check("order_second_addr", mem_addr, 32'h0000_5004);
        check("order_second_wdata", mem_wdata, 32'hD1D1_D1D1);
        tick();
        idle();
        check("order_third_addr", mem_addr, 32'h0000_5008);
        check("order_third_wdata", mem_wdata, 32'hD2D2_D2D2);
        tick();
        check("full_drained_empty", 32'(empty_from_sb), 32'h1);

        // Load hazard against a queued word
        mem_ready = 1'b0;
        put_store(3'b010, 32'h0000_3000, 32'h1111_1111);
        tick();
        idle();
        load_valid_from_memory = 1'b1;
        addr_from_memory = 32'h0000_3002;
        #1;
        check("load_hit_stall", 32'(stall_from_sb), 32'h1);
        addr_from_memory = 32'h0000_3004;
        #1;
        check("load_miss_nostall", 32'(stall_from_sb), 32'h0);
        addr_from_memory = 32'h0000_3002;
        tick();
        check("load_hit_hold", 32'(stall_from_sb), 32'h1);
        mem_ready = 1'b1;
        #1;
        check("load_hit_until_pop", 32'(stall_from_sb), 32'h1);
        tick();
        check("load_release", 32'(stall_from_sb), 32'h0);
        check("load_release_empty", 32'(empty_from_sb), 32'h1);
        idle();

        // Simultaneous push and pop with one entry queued
        mem_ready = 1'b0;
        put_store(3'b010, 32'h0000_6000, 32'h6666_0000);
        tick();
        put_store(3'b010, 32'h0000_6004, 32'h6666_0004);
        mem_ready = 1'b1;
        tick();
        idle();
        check("pushpop_not_empty", 32'(empty_from_sb), 32'h0);
        check("pushpop_head_addr", mem_addr, 32'h0000_6004);
        tick();
        check("pushpop_count_one", 32'(empty_from_sb), 32'h1);

        // Asynchronous reset while full and mid-handshake
        mem_ready = 1'b0;
        put_store(3'b010, 32'h0000_7000, 32'h7777_0000);
        tick();
        put_store(3'b010, 32'h0000_7004, 32'h7777_0004);
        tick();
        put_store(3'b001, 32'h0000_7001, 32'h0000_7777);
        #1;
        check("full_misaligned_nostall", 32'(stall_from_sb), 32'h0);
        tick();
        idle();
        check("pre_rst_misaligned", 32'(misaligned_from_sb), 32'h1);
        check("pre_rst_mem_req", 32'(mem_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'h0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_mem_wdata", mem_wdata, 32'h0);
        check("arst_mem_be", 32'(mem_be), 32'h0);
        check("arst_misaligned", 32'(misaligned_from_sb), 32'h0);
        check("arst_empty", 32'(empty_from_sb), 32'h1);
        check("arst_stall", 32'(stall_from_sb), 32'h0);
        tick();
        rst = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        check("post_rst_mem_req", 32'(mem_req), 32'h0);
        check("post_rst_empty", 32'(empty_from_sb), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
